mem_port_arbiter: RTL and testbench

Shares one single-port memory between the instruction-fetch stage and the data-memory stage of the VLIW pipeline. Requesters use a level request/done-pulse handshake; the arbiter drives the memory port and raises stall signals that feed the PC-write and pipeline-register enables. Data accesses win by default. An aging counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_wait_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory-port arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   OWN_I/OWN_D  - identifies which requester owns the memory port
//   MAX_WAIT_DEF - default number of lost cycles before fetch is forced through
//   WAIT_CNT_W   - width of the aging counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_CNT_W   = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating aging counter for the fetch requester.
//   clk, reset - clock, asynchronous active-high reset
//   inc_i      - fetch lost this cycle; count up (saturates at max_i)
//   clr_i      - fetch granted; clear (wins over inc_i)
//   max_i      - saturation value
//   sat_o      - count has reached max_i
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_i,
    input  logic                  clr_i,
    input  logic [WAIT_CNT_W-1:0] max_i,
    output logic                  sat_o
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < max_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == max_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data-memory stage. Data wins by default; an aging counter forces a
// fetch through once it has lost MAX_WAIT consecutive cycles.
//   clk, reset                      - clock, asynchronous active-high reset
//   if_req/if_addr                  - fetch request (level) and PC
//   if_done/if_rdata/if_stall       - fetch done pulse, instruction word, stall
//   d_req/d_we/d_addr/d_wdata       - data request (level), store flag, address, byte
//   d_done/d_rdata/d_stall          - data done pulse, load byte, stall
//   mem_req/mem_we/mem_addr/mem_wdata - registered memory command
//   mem_ready/mem_rdata             - memory completion and read data
//
// state  | meaning
// IDLE   | port free; grant an eligible requester this cycle
// BUSY_I | fetch access outstanding, waiting for mem_ready
// BUSY_D | data access outstanding, waiting for mem_ready
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int IDATA_W  = 32,
    parameter int DDATA_W  = 8,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_done,
    output logic [IDATA_W-1:0] if_rdata,
    output logic               if_stall,

    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DDATA_W-1:0] d_wdata,
    output logic               d_done,
    output logic [DDATA_W-1:0] d_rdata,
    output logic               d_stall,

    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [IDATA_W-1:0] mem_wdata,
    input  logic               mem_ready,
    input  logic [IDATA_W-1:0] mem_rdata
);

    localparam int PAD_W = IDATA_W - DDATA_W;

    arb_state_t         state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [IDATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic               if_done_q, if_done_d;
    logic               d_done_q, d_done_d;
    logic [IDATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DDATA_W-1:0] d_rdata_q, d_rdata_d;

    logic if_elig;
    logic d_elig;
    logic winner;
    logic grant_i;
    logic wait_inc;
    logic wait_sat;

    // A requester in its done cycle still holds req; it must not be granted again.
    assign if_elig = if_req & ~if_done_q;
    assign d_elig  = d_req & ~d_done_q;

    // Fetch ages whenever it wants the port but does not have it or get it.
    assign wait_inc = if_req & (state_q != BUSY_I) & ~grant_i;

    arb_wait_counter u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .inc_i (wait_inc),
        .clr_i (grant_i),
        .max_i (WAIT_CNT_W'(MAX_WAIT)),
        .sat_o (wait_sat)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_i     = 1'b0;
        winner      = OWN_D;

        case (state_q)
            IDLE: begin
                winner = (if_elig && (!d_elig || wait_sat)) ? OWN_I : OWN_D;
                if (if_elig || d_elig) begin
                    mem_req_d = 1'b1;
                    if (winner == OWN_I) begin
                        grant_i     = 1'b1;
                        state_d     = BUSY_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = BUSY_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = {{PAD_W{1'b0}}, d_wdata};
                    end
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata[DDATA_W-1:0];
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_done_q;
    assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int IDATA_W  = 32;
    localparam int DDATA_W  = 8;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset;

    logic               if_req, if_done, if_stall;
    logic [ADDR_W-1:0]  if_addr;
    logic [IDATA_W-1:0] if_rdata;
    logic               d_req, d_we, d_done, d_stall;
    logic [ADDR_W-1:0]  d_addr;
    logic [DDATA_W-1:0] d_wdata, d_rdata;
    logic               mem_req, mem_we, mem_ready;
    logic [ADDR_W-1:0]  mem_addr;
    logic [IDATA_W-1:0] mem_wdata, mem_rdata;

    // second instance with MAX_WAIT = 1 so the aging path becomes observable
    logic               if_req1, if_done1, if_stall1;
    logic [ADDR_W-1:0]  if_addr1;
    logic [IDATA_W-1:0] if_rdata1;
    logic               d_req1, d_we1, d_done1, d_stall1;
    logic [ADDR_W-1:0]  d_addr1;
    logic [DDATA_W-1:0] d_wdata1, d_rdata1;
    logic               mem_req1, mem_we1, mem_ready1;
    logic [ADDR_W-1:0]  mem_addr1;
    logic [IDATA_W-1:0] mem_wdata1, mem_rdata1;

    assign mem_ready1 = mem_req1;
    assign mem_rdata1 = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .IDATA_W(IDATA_W), .DDATA_W(DDATA_W), .MAX_WAIT(MAX_WAIT)
    ) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .IDATA_W(IDATA_W), .DDATA_W(DDATA_W), .MAX_WAIT(1)
    ) u_dut_w1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1), .if_rdata(if_rdata1), .if_stall(if_stall1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_done(d_done1), .d_rdata(d_rdata1), .d_stall(d_stall1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ready(mem_ready1), .mem_rdata(mem_rdata1)
    );

    typedef struct {
        logic        own_i;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } dtx_t;

    gnt_t        grant_q[$];
    dtx_t        d_txq[$];
    logic [31:0] i_txq[$];
    logic [31:0] exp_i_q[$];
    logic [7:0]  exp_d_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    int          cyc = 0;
    int          mcnt = 0;
    int          mem_waits = 0;
    logic        idle_noise = 1'b0;
    logic        prev_mreq = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic        cur_own_i = 1'b0;
    int          lost = 0;
    int          t_i_issue = 0;
    int          t_last_idone = -1;
    int          exp_ilat = 0;
    int          exp_iper = 0;
    int          last_fall = 0;
    int          gap_last = 0;
    int          n_istall = 0;
    int          n_mreq = 0;
    logic [7:0]  d_rdata_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hDEAD_BEAF;
    endfunction

    function automatic logic quiet();
        return (i_txq.size() == 0) && (d_txq.size() == 0) && !if_req && !d_req && !mem_req &&
               (grant_q.size() == 0) && (exp_i_q.size() == 0) && (exp_d_q.size() == 0);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_mcmd"}, {mem_req, mem_we}, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mwdata"}, mem_wdata, 0);
        check({tag, "_done"}, {if_done, d_done}, 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_stall"}, {if_stall, d_stall}, 0);
        check({tag, "_w1"}, {mem_req1, if_done1, d_done1}, 0);
    endtask

    // One clock cycle: observe the DUT, update requesters, model the memory.
    task automatic step();
        gnt_t        g;
        dtx_t        dt;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        cyc++;

        if (prev_mreq && mem_ready) begin
            check("complete", {mem_req, if_done, d_done}, {1'b0, cur_own_i, ~cur_own_i});
        end else begin
            if (if_done || d_done) check("spurious_done", {if_done, d_done}, 2'b00);
            if (prev_mreq) begin
                check("hold_cmd", {mem_req, mem_we, mem_addr}, {1'b1, prev_we, prev_addr});
                check("hold_wdata", mem_wdata, prev_wdata);
            end
        end
        if (prev_mreq && !mem_req) last_fall = cyc;
        if (!prev_mreq && mem_req) begin
            gap_last = cyc - last_fall;
            if (grant_q.size() == 0) begin
                check("grant_unexpected", 1, 0);
            end else begin
                g = grant_q.pop_front();
                check("gnt_we", mem_we, g.we);
                check("gnt_addr", mem_addr, g.addr);
                check("gnt_wdata", mem_wdata, g.wdata);
                cur_own_i = g.own_i;
                if (g.own_i) begin
                    check("fetch_wait", ((lost - 1) <= MAX_WAIT), 1'b1);
                    lost = 0;
                end
            end
        end
        if (if_done) begin
            if (exp_i_q.size() == 0) check("if_done_unexpected", 1, 0);
            else check("if_rdata", if_rdata, exp_i_q.pop_front());
            if (exp_ilat != 0) check("if_latency", cyc - t_i_issue, exp_ilat);
            if (exp_iper != 0 && t_last_idone >= 0) check("if_period", cyc - t_last_idone, exp_iper);
            t_last_idone = cyc;
        end
        if (d_done) begin
            if (exp_d_q.size() == 0) check("d_done_unexpected", 1, 0);
            else check("d_rdata", d_rdata, exp_d_q.pop_front());
        end

        if (if_done || !if_req) begin
            if (i_txq.size() > 0) begin
                if_addr = i_txq.pop_front();
                if_req  = 1'b1;
                exp_i_q.push_back(mem_fn(if_addr));
                t_i_issue = cyc;
            end else begin
                if_req = 1'b0;
            end
        end
        if (d_done || !d_req) begin
            if (d_txq.size() > 0) begin
                dt = d_txq.pop_front();
                d_req   = 1'b1;
                d_we    = dt.we;
                d_addr  = dt.addr;
                d_wdata = dt.wdata;
                if (!dt.we) begin
                    rd = mem_fn(dt.addr);
                    d_rdata_exp = rd[7:0];
                end
                exp_d_q.push_back(d_rdata_exp);
            end else begin
                d_req = 1'b0;
            end
        end

        prev_mreq  = mem_req;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (mem_req) begin
            mem_ready = (mcnt == mem_waits);
            mem_rdata = mem_ready ? mem_fn(mem_addr) : 32'h0;
            mcnt      = mem_ready ? 0 : mcnt + 1;
        end else begin
            mem_ready = idle_noise;
            mem_rdata = 32'hFFFF_FFFF;
            mcnt      = 0;
        end

        #1;
        check("if_stall", if_stall, if_req & ~if_done);
        check("d_stall", d_stall, d_req & ~d_done);
        if (if_stall) n_istall++;
        if (mem_req) n_mreq++;
        if (if_stall && !(mem_req && cur_own_i)) lost++;
    endtask

    task automatic run_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc) begin
            step();
            n++;
            if (quiet()) break;
        end
        check({tag, "_drain"}, quiet(), 1'b1);
    endtask

    initial begin
        int  n;
        logic saw;
        reset = 1'b1;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst0");
        @(negedge clk) reset = 1'b0;

        // reset in the middle of a stalled load
        mem_waits = 50;
        d_txq.push_back('{1'b0, 32'h80, 8'h00});
        grant_q.push_back('{1'b0, 1'b0, 32'h80, 32'h0});
        repeat (4) step();
        check("rst_pre_mreq", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_mreq", mem_req, 1'b0);
        check("rst_no_done", d_done, 1'b0);
        d_req = 0; d_txq.delete(); exp_d_q.delete(); grant_q.delete();
        d_rdata_exp = '0; mem_ready = 0; mem_waits = 0; prev_mreq = 0; mcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_mid");

        // single fetch, zero-wait memory
        exp_ilat = 2; n_istall = 0;
        i_txq.push_back(32'h40);
        grant_q.push_back('{1'b1, 1'b0, 32'h40, 32'h0});
        run_idle("single", 20);
        check("single_istall", n_istall, 2);
        check("single_rdata", if_rdata, 32'hDEAD_BEEF);
        exp_ilat = 0;

        // fetch and load collide: data first, fetch granted in the d_done cycle
        d_txq.push_back('{1'b0, 32'h100, 8'h00});
        i_txq.push_back(32'h44);
        grant_q.push_back('{1'b0, 1'b0, 32'h100, 32'h0});
        grant_q.push_back('{1'b1, 1'b0, 32'h44, 32'h0});
        run_idle("collide", 30);
        check("collide_gap", gap_last, 1);
        check("collide_d_rdata", d_rdata, 8'hAF);

        // store with wait states: load byte must be untouched
        mem_waits = 2; n_mreq = 0;
        d_txq.push_back('{1'b1, 32'h10, 8'hA5});
        grant_q.push_back('{1'b0, 1'b1, 32'h10, 32'h0000_00A5});
        run_idle("store", 30);
        check("store_mreq_cycles", n_mreq, 3);
        check("store_d_rdata", d_rdata, 8'hAF);

        // continuous data traffic with fetch pending; spurious mem_ready in idle
        mem_waits = 1; idle_noise = 1'b1;
        for (int k = 0; k < 4; k++) d_txq.push_back('{1'b0, 32'h200 + 32'(4 * k), 8'h00});
        for (int k = 0; k < 3; k++) i_txq.push_back(32'h80 + 32'(4 * k));
        for (int k = 0; k < 4; k++) begin
            grant_q.push_back('{1'b0, 1'b0, 32'h200 + 32'(4 * k), 32'h0});
            if (k < 3) grant_q.push_back('{1'b1, 1'b0, 32'h80 + 32'(4 * k), 32'h0});
        end
        run_idle("starve", 100);
        check("starve_d_rdata", d_rdata, 8'hA3);
        check("starve_if_rdata", if_rdata, 32'hDEAD_BE27);
        idle_noise = 1'b0;

        // back-to-back fetches with if_req held
        mem_waits = 0; exp_iper = 3; t_last_idone = -1;
        for (int k = 0; k < 4; k++) begin
            i_txq.push_back(32'h100 + 32'(4 * k));
            grant_q.push_back('{1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0});
        end
        run_idle("b2b", 40);
        exp_iper = 0;

        // MAX_WAIT = 1: the fetch done cycle ages fetch to saturation,
        // so a simultaneous fetch/data request next is won by fetch
        if_addr1 = 32'h200; d_addr1 = 32'h300; d_we1 = 1'b0; if_req1 = 1'b1;
        n = 0;
        while (!if_done1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w1_first_done", if_done1, 1'b1);
        @(posedge clk);
        #1;
        d_req1 = 1'b1;
        @(posedge clk);
        #1;
        check("w1_aged_grant", {mem_req1, mem_we1, mem_addr1}, {1'b1, 1'b0, 32'h200});
        if_req1 = 1'b0;
        saw = 1'b0;
        n = 0;
        while (!d_done1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (if_done1) saw = 1'b1;
            if (mem_req1) check("w1_d_addr", mem_addr1, 32'h300);
        end
        check("w1_dropped_req_done", saw, 1'b1);
        check("w1_d_done", d_done1, 1'b1);
        d_req1 = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
